// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: SYNC, PID, optional payload and CRC bytes, then EOP handshake.
// Build option USB_TX_CRC16_EN: generate the CRC16 internally instead of popping it from the buffer.
module usb_tx_sequencer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic       rx_transfer_active,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       eop_req,
    input  logic       eop_done,
    output logic       tx_transfer_active,
    output logic       tx_error
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        PID    = 3'd2,
        DATA   = 3'd3,
        CRC_LO = 3'd4,
        CRC_HI = 3'd5,
        EOP    = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [6:0] count_q, count_d;
    logic       eop_req_q, eop_req_d;
    logic       active_q, active_d;
    logic       error_q, error_d;
    logic [7:0] byte_s;
    logic       valid_s;
    logic       pop_s;
    logic       code_valid_s;
    logic       code_data_s;
    logic       short_s;
    logic       buf_empty_s;
    logic [6:0] snap_s;
    logic [6:0] start_count_s;

    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        logic [7:0] pid;
        case (code)
            3'd1:    pid = 8'hC3;
            3'd2:    pid = 8'h4B;
            3'd3:    pid = 8'hD2;
            3'd4:    pid = 8'h5A;
            3'd5:    pid = 8'h1E;
            default: pid = 8'h00;
        endcase
        return pid;
    endfunction

    assign code_valid_s = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
    assign code_data_s  = (tx_packet == 3'd1) || (tx_packet == 3'd2);
    assign snap_s       = (buffer_occupancy > 7'd64) ? 7'd64 : buffer_occupancy;
    assign buf_empty_s  = (buffer_occupancy == 7'd0);

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;

    // Reflected CRC16 (poly 0x8005) update over one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign short_s       = 1'b0;
    assign start_count_s = code_data_s ? snap_s : 7'd0;
`else
    // The two trailing buffer bytes are the CRC, so the payload is two shorter.
    assign short_s       = code_data_s && (snap_s < 7'd2);
    assign start_count_s = code_data_s ? (snap_s - 7'd2) : 7'd0;
`endif

    // Next-state, byte presentation and buffer pop decode.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        error_d = error_q;
        byte_s  = 8'h00;
        valid_s = 1'b0;
        pop_s   = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start && code_valid_s) begin
                    if (rx_transfer_active) begin
                        error_d = 1'b1;
                    end else if (short_s) begin
                        error_d = 1'b1;
                    end else begin
                        code_d  = tx_packet;
                        count_d = start_count_s;
                        error_d = 1'b0;
                        state_d = SYNC;
`ifdef USB_TX_CRC16_EN
                        crc_d   = 16'hFFFF;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                valid_s = 1'b1;
                byte_s  = 8'h80;
                if (byte_ready) begin
                    state_d = PID;
                end else begin
                    state_d = SYNC;
                end
            end
            PID: begin
                valid_s = 1'b1;
                byte_s  = pid_byte(code_q);
                if (!byte_ready) begin
                    state_d = PID;
                end else if ((code_q == 3'd1) || (code_q == 3'd2)) begin
                    state_d = (count_q == 7'd0) ? CRC_LO : DATA;
                end else begin
                    state_d = EOP;
                end
            end
            DATA: begin
                if (buf_empty_s) begin
                    error_d = 1'b1;
                    state_d = EOP;
                end else begin
                    valid_s = 1'b1;
                    byte_s  = tx_packet_data;
                    if (byte_ready) begin
                        pop_s   = 1'b1;
                        count_d = count_q - 7'd1;
`ifdef USB_TX_CRC16_EN
                        crc_d   = crc16_byte(crc_q, tx_packet_data);
`endif
                        state_d = (count_q == 7'd1) ? CRC_LO : DATA;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            CRC_LO, CRC_HI: begin
`ifdef USB_TX_CRC16_EN
                valid_s = 1'b1;
                byte_s  = (state_q == CRC_LO) ? ~crc_q[7:0] : ~crc_q[15:8];
                if (byte_ready) begin
                    state_d = (state_q == CRC_LO) ? CRC_HI : EOP;
                end else begin
                    state_d = state_q;
                end
`else
                if (buf_empty_s) begin
                    error_d = 1'b1;
                    state_d = EOP;
                end else begin
                    valid_s = 1'b1;
                    byte_s  = tx_packet_data;
                    if (byte_ready) begin
                        pop_s   = 1'b1;
                        state_d = (state_q == CRC_LO) ? CRC_HI : EOP;
                    end else begin
                        state_d = state_q;
                    end
                end
`endif
            end
            EOP: begin
                // eop_done in the request cycle belongs to nobody; wait for a fresh one.
                if (eop_done && !eop_req_q) begin
                    state_d = DONE;
                end else begin
                    state_d = EOP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        eop_req_d = (state_d == EOP) && (state_q != EOP);
        active_d  = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            code_q    <= 3'd0;
            count_q   <= 7'd0;
            eop_req_q <= 1'b0;
            active_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            count_q   <= count_d;
            eop_req_q <= eop_req_d;
            active_q  <= active_d;
            error_q   <= error_d;
        end
    end

`ifdef USB_TX_CRC16_EN
    // CRC accumulator.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    assign byte_out           = byte_s;
    assign byte_valid         = valid_s;
    assign get_tx_packet_data = pop_s;
    assign eop_req            = eop_req_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = error_q;
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: vector table, corner sequences and random packets
// against a packet-level reference model (honours USB_TX_CRC16_EN).
module tb_usb_tx_sequencer;
`ifdef USB_TX_CRC16_EN
    localparam int CRC = 1;
`else
    localparam int CRC = 0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic       rx_transfer_active;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       eop_req;
    logic       eop_done;
    logic       tx_transfer_active;
    logic       tx_error;

    always #5 clk = ~clk;

    usb_tx_sequencer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .rx_transfer_active (rx_transfer_active),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .eop_req            (eop_req),
        .eop_done           (eop_done),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    typedef struct {
        int code;
        bit rx;
        int nbuf;
        int mode;
        int exp_err;
        int exp_len;
        int exp_pops;
    } vec_t;

    vec_t       tbl[11];
    bit [7:0]   pid_tab[8] = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h00, 8'h00};
    bit [7:0]   buf_q[$];
    bit [7:0]   got_q[$];
    int         checks = 0;
    int         failures = 0;
    int         pops, eops, active_cycles, stall_viol, pop_viol, idle_valid;
    int         ready_mode = 0;
    bit         toggle_ph = 1'b0;
    int         eop_delay = 1;
    int         eop_cnt = -1;
    bit         stall_pending = 1'b0;
    bit [7:0]   prev_byte = 8'h00;
    bit         start_pend = 1'b0;
    bit [2:0]   start_code = 3'd0;
    bit         model_err = 1'b0;
    int         cur_code = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (code %0d, t=%0t)", name, act, exp, cur_code, $time);
        end
    endtask

    // CRC-16/USB from its definition: MSB-first division by 0x8005 on the bit stream, then reflect and invert.
    function automatic bit [15:0] model_crc(input bit [7:0] d[$]);
        bit [15:0] r;
        bit [15:0] o;
        bit        fb;
        r = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ d[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int k = 0; k < 16; k++) o[k] = r[15-k];
        return ~o;
    endfunction

    // One clock: drive inputs on the falling edge, then observe the encoder/buffer side.
    task automatic step();
        @(negedge clk);
        tx_start  = start_pend;
        tx_packet = start_code;
        start_pend = 1'b0;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       begin byte_ready = toggle_ph; toggle_ph = ~toggle_ph; end
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
        buffer_occupancy = 7'(buf_q.size());
        tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
        eop_done = (eop_cnt == 0);
        if (eop_cnt >= 0) eop_cnt--;
        #1;
        if (stall_pending && !(byte_valid === 1'b1 && byte_out === prev_byte)) stall_viol++;
        if (byte_valid && byte_ready) got_q.push_back(byte_out);
        stall_pending = byte_valid && !byte_ready;
        prev_byte     = byte_out;
        if (get_tx_packet_data) begin
            pops++;
            if (!(byte_valid && byte_ready)) pop_viol++;
            if (buf_q.size() > 0) void'(buf_q.pop_front());
        end
        if (eop_req) begin
            eops++;
            eop_cnt = eop_delay;
        end
        if (tx_transfer_active) active_cycles++;
        if (!tx_transfer_active && byte_valid) idle_valid++;
    endtask

    task automatic clear_mon();
        got_q.delete();
        pops = 0; eops = 0; active_cycles = 0; stall_viol = 0; pop_viol = 0; idle_valid = 0;
        eop_cnt = -1; stall_pending = 1'b0;
    endtask

    // Issue one command, run it to completion and compare with the model (and table, when given).
    task automatic run_txn(input int code, input bit rx, input int nbuf, input int mode,
                           input int inj_c, input int inj_code,
                           input int x_err, input int x_len, input int x_pops);
        bit [7:0]  snap[$];
        bit [7:0]  expq[$];
        bit [15:0] crc;
        int        n;
        int        e_pops;
        bit        acc, seen, done;
        cur_code = code;
        buf_q.delete();
        for (int i = 0; i < nbuf; i++) buf_q.push_back(8'($urandom_range(0, 255)));
        n = (nbuf > 64) ? 64 : nbuf;
        for (int i = 0; i < n; i++) snap.push_back(buf_q[i]);
        acc = 1'b0;
        e_pops = 0;
        if (code >= 1 && code <= 5) begin
            if (rx) begin
                model_err = 1'b1;
            end else if ((code == 1 || code == 2) && CRC == 0 && n < 2) begin
                model_err = 1'b1;
            end else begin
                acc = 1'b1;
                model_err = 1'b0;
                expq.push_back(8'h80);
                expq.push_back(pid_tab[code]);
                if (code == 1 || code == 2) begin
                    foreach (snap[i]) expq.push_back(snap[i]);
                    e_pops = n;
                    if (CRC != 0) begin
                        crc = model_crc(snap);
                        expq.push_back(crc[7:0]);
                        expq.push_back(crc[15:8]);
                    end
                end
            end
        end

        clear_mon();
        ready_mode = mode;
        eop_delay  = $urandom_range(0, 3);
        rx_transfer_active = rx;
        start_pend = 1'b1;
        start_code = 3'(code);
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            if (c == inj_c) begin
                start_pend = 1'b1;
                start_code = 3'(inj_code);
            end
            step();
            if (tx_transfer_active) seen = 1'b1;
            if (acc ? (seen && !tx_transfer_active) : (c >= 6)) done = 1'b1;
        end
        rx_transfer_active = 1'b0;

        check("txn_complete", int'(done), 1);
        check("byte_count", got_q.size(), expq.size());
        foreach (expq[i]) check("byte_value", (i < got_q.size()) ? int'(got_q[i]) : 32'hDEAD, int'(expq[i]));
        check("tx_error", int'(tx_error), int'(model_err));
        check("pop_count", pops, e_pops);
        check("eop_req_count", eops, acc ? 1 : 0);
        check("stall_stability", stall_viol, 0);
        check("pop_without_accept", pop_viol, 0);
        check("valid_while_inactive", idle_valid, 0);
        check("active_duration", int'(acc ? (active_cycles >= 5) : (active_cycles == 0)), 1);
        if (x_err >= 0) check("tbl_err", int'(tx_error), x_err);
        if (x_len >= 0) check("tbl_len", got_q.size(), x_len);
        if (x_pops >= 0) check("tbl_pops", pops, x_pops);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb_before;
        n_rst = 1'b0;
        tx_start = 1'b0; tx_packet = 3'd0; rx_transfer_active = 1'b0; byte_ready = 1'b0;
        eop_done = 1'b0; buffer_occupancy = 7'd0; tx_packet_data = 8'h00;

        //            code rx nbuf mode err      len          pops
        tbl[0]  = '{3, 1'b0, 0, 0, 0,       2,           0};
        tbl[1]  = '{1, 1'b0, 0, 0, 1 - CRC, 4 * CRC,     0};
        tbl[2]  = '{2, 1'b0, 5, 1, 0,       7 + 2 * CRC, 5};
        tbl[3]  = '{4, 1'b1, 0, 0, 1,       0,           0};
        tbl[4]  = '{4, 1'b0, 0, 0, 0,       2,           0};
        tbl[5]  = '{5, 1'b0, 0, 2, 0,       2,           0};
        tbl[6]  = '{1, 1'b0, 3, 2, 0,       5 + 2 * CRC, 3};
        tbl[7]  = '{0, 1'b0, 2, 0, 0,       0,           0};
        tbl[8]  = '{2, 1'b0, 1, 0, 1 - CRC, 5 * CRC,     CRC};
        tbl[9]  = '{6, 1'b0, 0, 1, 1 - CRC, 0,           0};
        tbl[10] = '{7, 1'b1, 0, 0, 1 - CRC, 0,           0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_byte_out", int'(byte_out), 0);
        check("rst_get", int'(get_tx_packet_data), 0);
        check("rst_eop_req", int'(eop_req), 0);
        check("rst_active", int'(tx_transfer_active), 0);
        check("rst_error", int'(tx_error), 0);
        n_rst = 1'b1;

        for (int i = 0; i < 11; i++)
            run_txn(tbl[i].code, tbl[i].rx, tbl[i].nbuf, tbl[i].mode, -1, 0,
                    tbl[i].exp_err, tbl[i].exp_len, tbl[i].exp_pops);

        // Invalid code and a second valid start arriving mid-packet must not disturb it.
        run_txn(1, 1'b0, 4, 0, 3, 7, 0, 2 + 4 + 2 * CRC, 4);
        run_txn(2, 1'b0, 4, 0, 3, 3, 0, 2 + 4 + 2 * CRC, 4);

        // Asynchronous reset while the third data byte of eight is on the wire.
        cur_code = 1;
        buf_q.delete();
        for (int i = 0; i < 8; i++) buf_q.push_back(8'($urandom_range(0, 255)));
        clear_mon();
        ready_mode = 0;
        start_pend = 1'b1;
        start_code = 3'd1;
        for (int c = 0; c < 50 && pops < 2; c++) step();
        check("rst_reach_byte3", pops, 2);
        step();
        check("rst_pre_valid", int'(byte_valid), 1);
        nb_before = got_q.size();
        #1 n_rst = 1'b0;
        #1;
        check("midrst_byte_valid", int'(byte_valid), 0);
        check("midrst_byte_out", int'(byte_out), 0);
        check("midrst_get", int'(get_tx_packet_data), 0);
        check("midrst_eop_req", int'(eop_req), 0);
        check("midrst_active", int'(tx_transfer_active), 0);
        repeat (3) step();
        @(negedge clk);
        n_rst = 1'b1;
        model_err = 1'b0;
        repeat (10) step();
        check("midrst_no_eop", eops, 0);
        check("midrst_no_more_bytes", got_q.size(), nb_before);
        check("midrst_idle", int'(tx_transfer_active), 0);

        // Reset also clears a sticky error.
        run_txn(5, 1'b1, 0, 0, -1, 0, 1, 0, 0);
        #2 n_rst = 1'b0;
        #1;
        check("rst_clears_error", int'(tx_error), 0);
        @(negedge clk);
        n_rst = 1'b1;
        model_err = 1'b0;

        for (int r = 0; r < 40; r++)
            run_txn($urandom_range(0, 7), ($urandom_range(0, 5) == 0), $urandom_range(0, 12),
                    $urandom_range(0, 2), -1, 0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_tx_sequencer.md
USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port tx_start  input  1  one-cycle command strobe; tx_packet sampled the same cycle.
REQ-004 SHALL have port tx_packet  input  3  packet code: 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 0/6/7 invalid.
REQ-005 SHALL have port rx_transfer_active  input  1  receiver currently busy.
REQ-006 SHALL have port buffer_occupancy  input  7  bytes held in data buffer, 0..64.
REQ-007 SHALL have port tx_packet_data  input  8  head byte of data buffer, valid while occupancy>0.
REQ-008 SHALL have port get_tx_packet_data  output  1  one-cycle pop of buffer head byte.
REQ-009 SHALL have port byte_out  output  8  byte presented to the bit encoder.
REQ-010 SHALL have port byte_valid  output  1  byte_out valid.
REQ-011 SHALL have port byte_ready  input  1  encoder accepts byte_out this cycle.
REQ-012 SHALL have port eop_req  output  1  one-cycle request for end-of-packet signalling.
REQ-013 SHALL have port eop_done  input  1  encoder has finished EOP.
REQ-014 SHALL have port tx_transfer_active  output  1  high from accepted tx_start to end of DONE.
REQ-015 SHALL have port tx_error  output  1  sticky error flag.

Function
REQ-016 SHALL implement states IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
REQ-017 SHALL, in IDLE on tx_start with valid code and rx_transfer_active=0, latch the code, snapshot min(buffer_occupancy,64) as byte count, clear tx_error, and enter SYNC the next cycle.
REQ-018 SHALL ignore tx_start with invalid code and ignore any tx_start outside IDLE.
REQ-019 SHALL, on valid tx_start while rx_transfer_active=1, set tx_error, transmit nothing, and remain in IDLE.
REQ-020 SHALL hold byte_valid high and byte_out stable until byte_ready is sampled high; a byte is transferred on that edge; the next byte may be valid in the following cycle.
REQ-021 SHALL send SYNC byte 0x80, then the PID byte: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
REQ-022 SHALL, for ACK/NAK/STALL, go from PID straight to EOP.
REQ-023 SHALL, for DATA0/DATA1, send exactly the snapshot count of buffer bytes in DATA, pulsing get_tx_packet_data in the cycle each data byte is accepted, and then send CRC_LO and CRC_HI.
REQ-024 SHALL, for a zero snapshot count, skip DATA (zero-length packet).
REQ-025 SHALL, if buffer_occupancy is 0 while data bytes remain in DATA, set tx_error and go to EOP without popping.
REQ-026 SHALL, in EOP, pulse eop_req for one cycle on entry and then wait for eop_done; next state DONE.
REQ-027 SHALL spend exactly one cycle in DONE, then return to IDLE, deasserting tx_transfer_active on that return.
REQ-028 SHALL keep byte_valid low in IDLE, EOP and DONE.

Reset
REQ-029 SHALL, on n_rst low, enter IDLE immediately, drive all outputs 0 and clear the CRC, count and code registers, including mid-packet; no EOP is issued.

Configuration
REQ-030 SHALL honour macro USB_TX_CRC16_EN: when defined, CRC16 (poly 0x8005, init 0xFFFF, LSB-first, result inverted) is computed over data bytes; CRC_LO sends the low byte and CRC_HI the high byte.
REQ-031 SHALL, when USB_TX_CRC16_EN is undefined, send the two CRC bytes by popping them from the buffer like data, so the snapshot count includes them. A snapshot below 2 sets tx_error and sends no packet.

Verification
REQ-032 SHALL cover: tx_start, code 3, byte_ready tied high -> bytes 0x80,0xD2, one eop_req, tx_transfer_active high 5 cycles minimum.
REQ-033 SHALL cover: code 1 with occupancy 0, CRC16 enabled -> bytes 0x80,0xC3,0x00,0x00, no get_tx_packet_data pulse.
REQ-034 SHALL cover: code 2, 5 bytes buffered, byte_ready toggling every other cycle -> 5 pops in order, byte_out stable while stalled, CRC matching the model.
REQ-035 SHALL cover: code 4 while rx_transfer_active=1 -> tx_error=1, byte_valid never high; a later code 4 with rx idle -> tx_error cleared, 0x80,0x5A sent.
REQ-036 SHALL cover: n_rst pulsed low during DATA byte 3 of 8 -> all outputs 0 asynchronously, IDLE, no eop_req.
REQ-037 SHALL cover: code 7 and a second tx_start mid-packet -> both ignored, packet in progress unaffected.
